ahb_master_bridge: RTL and testbench

- Single-outstanding AHB-Lite master that converts the PicoRV32 native memory interface (mem_valid/mem_ready) into single NONSEQ AHB transfers.
- Sits between the CPU core and the AHB interconnect/decoder, and drives slaves such as the on-chip RAM.
- Generates byte/halfword/word writes from mem_wstrb and returns read data to the core.
- Performs no bursts and no pipelining of back-to-back requests.

---
 rtl/ahb_master_bridge.sv | 162 ++++++++++++++++
 tb/tb_ahb_master_bridge.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/ahb_master_bridge.sv
// Single-outstanding AHB-Lite master: turns one PicoRV32 native memory request
// into one SINGLE/NONSEQ transfer and returns the completion on mem_ready/mem_rdata.
module ahb_master_bridge #(
    parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic [1:0]  htrans,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic [31:0] hwdata,
    input  logic        hready,
    input  logic [31:0] hrdata,
    input  logic [1:0]  hresp,
    output logic        bus_err
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    localparam logic [1:0] HTRANS_IDLE    = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ  = 2'b10;
    localparam logic [1:0] HRESP_ERROR    = 2'b01;

    state_t      state_q, state_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [3:0]  hprot_q, hprot_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        mem_ready_q, mem_ready_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        bus_err_q, bus_err_d;

    logic        dec_ok;
    logic [2:0]  dec_size;
    logic [1:0]  dec_lo;

    // The byte offset comes from the strobe pattern, not from mem_addr[1:0].
    logic        unused_addr_lo;
    assign unused_addr_lo = ^mem_addr[1:0];

    always_comb begin
        dec_ok   = 1'b1;
        dec_size = 3'b010;
        dec_lo   = 2'b00;
        case (mem_wstrb)
            4'b0000: dec_size = 3'b010;
            4'b1111: dec_size = 3'b010;
            4'b0011: dec_size = 3'b001;
            4'b1100: begin dec_size = 3'b001; dec_lo = 2'b10; end
            4'b0001: dec_size = 3'b000;
            4'b0010: begin dec_size = 3'b000; dec_lo = 2'b01; end
            4'b0100: begin dec_size = 3'b000; dec_lo = 2'b10; end
            4'b1000: begin dec_size = 3'b000; dec_lo = 2'b11; end
            default: dec_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hprot_d     = hprot_q;
        hwdata_d    = hwdata_q;
        mem_ready_d = 1'b0;
        mem_rdata_d = mem_rdata_q;
        bus_err_d   = bus_err_q;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    if (dec_ok) begin
                        state_d  = S_ADDR;
                        htrans_d = HTRANS_NONSEQ;
                        haddr_d  = {mem_addr[31:2], dec_lo};
                        hwrite_d = |mem_wstrb;
                        hsize_d  = dec_size;
                        hprot_d  = mem_instr ? 4'b0010 : 4'b0011;
                    end else begin
                        // Illegal strobe: complete locally without touching the bus.
                        state_d     = S_RESP;
                        mem_ready_d = 1'b1;
                        mem_rdata_d = ERR_RDATA;
                        bus_err_d   = 1'b1;
                    end
                end
            end
            S_ADDR: begin
                if (hready) begin
                    state_d  = S_DATA;
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = mem_wdata;
                end
            end
            S_DATA: begin
                // First cycle of a two-cycle ERROR has hready=0 and is just a wait.
                if (hready) begin
                    state_d     = S_RESP;
                    mem_ready_d = 1'b1;
                    if (hresp == HRESP_ERROR) begin
                        mem_rdata_d = ERR_RDATA;
                        bus_err_d   = 1'b1;
                    end else begin
                        mem_rdata_d = hrdata;
                    end
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q     <= S_IDLE;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= 32'h0;
            hwrite_q    <= 1'b0;
            hsize_q     <= 3'b010;
            hprot_q     <= 4'b0011;
            hwdata_q    <= 32'h0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'h0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hprot_q     <= hprot_d;
            hwdata_q    <= hwdata_d;
            mem_ready_q <= mem_ready_d;
            mem_rdata_q <= mem_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign htrans    = htrans_q;
    assign haddr     = haddr_q;
    assign hwrite    = hwrite_q;
    assign hsize     = hsize_q;
    assign hburst    = 3'b000;
    assign hprot     = hprot_q;
    assign hwdata    = hwdata_q;
    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_ahb_master_bridge.sv
// Scoreboard bench for ahb_master_bridge: the bench plays both the core and a
// simple AHB slave; expected completions are queued at request time.
module tb_ahb_master_bridge;

    localparam logic [31:0] ERR = 32'hBAD0_0BAD;

    logic        clk = 1'b0;
    logic        hreset;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [1:0]  htrans;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic [31:0] hrdata;
    logic [1:0]  hresp;
    logic        bus_err;

    ahb_master_bridge #(.ERR_RDATA(ERR)) dut (
        .hclk(clk), .hreset(hreset),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .htrans(htrans), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .hprot(hprot), .hwdata(hwdata),
        .hready(hready), .hrdata(hrdata), .hresp(hresp), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        chk_rdata;
        int          lat;
        int          nonseq;
        logic        berr;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic berr_model = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Runs one core request; called just after a falling edge.
    task automatic txn(input logic [31:0] addr, input logic [3:0] strb, input logic [31:0] wd,
                       input logic instr, input int waits, input logic err, input logic [31:0] srd,
                       input logic [31:0] e_haddr, input logic [2:0] e_size, input logic legal);
        exp_t e, got_e;
        int   cyc = 0, nonseq = 0, w = waits;
        logic done = 1'b0, in_data = 1'b0;
        if (!legal || err) berr_model = 1'b1;
        e.rdata     = (legal && !err) ? srd : ERR;
        e.chk_rdata = (strb == 4'b0000) || !legal || err;
        e.lat       = legal ? 3 + waits : 1;
        e.nonseq    = legal ? 1 : 0;
        e.berr      = berr_model;
        sb.push_back(e);
        mem_valid = 1'b1; mem_instr = instr; mem_addr = addr; mem_wdata = wd; mem_wstrb = strb;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            hready = 1'b1; hresp = 2'b00; hrdata = 32'hFFFF_FFFF;
            if (in_data) begin
                check_eq("data_htrans", {30'd0, htrans}, 32'd0);
                check_eq("hwdata", hwdata, wd);
                check_eq("data_haddr", haddr, e_haddr);
                hresp = err ? 2'b01 : 2'b00;
                if (w > 0) begin
                    hready = 1'b0;
                    w--;
                end else begin
                    hrdata  = srd;
                    in_data = 1'b0;
                end
            end else if (htrans == 2'b10) begin
                nonseq++;
                check_eq("haddr", haddr, e_haddr);
                check_eq("hsize", {29'd0, hsize}, {29'd0, e_size});
                check_eq("hwrite", {31'd0, hwrite}, {31'd0, |strb});
                check_eq("hprot", {28'd0, hprot}, instr ? 32'h2 : 32'h3);
                check_eq("hburst", {29'd0, hburst}, 32'd0);
                in_data = 1'b1;
            end
            if (mem_ready) begin
                got_e = sb.pop_front();
                if (got_e.chk_rdata) check_eq("mem_rdata", mem_rdata, got_e.rdata);
                check_eq("latency", cyc, got_e.lat);
                check_eq("nonseq_count", nonseq, got_e.nonseq);
                check_eq("bus_err", {31'd0, bus_err}, {31'd0, got_e.berr});
                done = 1'b1;
                mem_valid = 1'b0;
            end
        end
        if (!done) begin
            check_eq("timeout", 32'd0, 32'd1);
            void'(sb.pop_front());
            mem_valid = 1'b0;
        end
        @(negedge clk);
        check_eq("ready_pulse", {31'd0, mem_ready}, 32'd0);
        check_eq("idle_gap", {30'd0, htrans}, 32'd0);
        $display("txn addr=%h strb=%b waits=%0d err=%0b done=%0b rdata=%h", addr, strb, waits, err, done, mem_rdata);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_htrans"}, {30'd0, htrans}, 32'd0);
        check_eq({tag, "_haddr"}, haddr, 32'd0);
        check_eq({tag, "_hwrite"}, {31'd0, hwrite}, 32'd0);
        check_eq({tag, "_hsize"}, {29'd0, hsize}, 32'd2);
        check_eq({tag, "_hprot"}, {28'd0, hprot}, 32'd3);
        check_eq({tag, "_hwdata"}, hwdata, 32'd0);
        check_eq({tag, "_ready"}, {31'd0, mem_ready}, 32'd0);
        check_eq({tag, "_rdata"}, mem_rdata, 32'd0);
        check_eq({tag, "_buserr"}, {31'd0, bus_err}, 32'd0);
    endtask

    initial begin
        hreset = 1'b1; mem_valid = 1'b0; mem_instr = 1'b0; mem_addr = '0; mem_wdata = '0;
        mem_wstrb = '0; hready = 1'b1; hrdata = '0; hresp = 2'b00;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        hreset = 1'b0;
        @(negedge clk);

        txn(32'h10,  4'b0000, 32'h0,         1'b0, 0, 1'b0, 32'hDEAD_BEEF, 32'h10,  3'b010, 1'b1);
        txn(32'h14,  4'b0000, 32'h0,         1'b1, 0, 1'b0, 32'h0000_0013, 32'h14,  3'b010, 1'b1);
        txn(32'h103, 4'b1000, 32'hAB00_0000, 1'b0, 0, 1'b0, 32'h0,         32'h103, 3'b000, 1'b1);
        txn(32'h20,  4'b1100, 32'h1234_0000, 1'b0, 0, 1'b0, 32'h0,         32'h22,  3'b001, 1'b1);
        txn(32'h20,  4'b0011, 32'h0000_5678, 1'b0, 0, 1'b0, 32'h0,         32'h20,  3'b001, 1'b1);
        txn(32'h30,  4'b1111, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 32'h0,         32'h30,  3'b010, 1'b1);
        txn(32'h201, 4'b0010, 32'h0000_7700, 1'b0, 0, 1'b0, 32'h0,         32'h201, 3'b000, 1'b1);
        txn(32'h13,  4'b0000, 32'h0,         1'b0, 0, 1'b0, 32'h0BAD_CAFE, 32'h10,  3'b010, 1'b1);
        txn(32'h50,  4'b0000, 32'h5555_AAAA, 1'b0, 3, 1'b0, 32'h1234_5678, 32'h50,  3'b010, 1'b1);
        txn(32'h60,  4'b0000, 32'h0,         1'b0, 1, 1'b1, 32'h0000_0055, 32'h60,  3'b010, 1'b1);
        txn(32'h64,  4'b0000, 32'h0,         1'b0, 0, 1'b0, 32'h7777_1111, 32'h64,  3'b010, 1'b1);
        txn(32'h70,  4'b0110, 32'h0,         1'b0, 0, 1'b0, 32'h0,         32'h0,   3'b010, 1'b0);
        txn(32'h74,  4'b0000, 32'h0,         1'b0, 0, 1'b0, 32'h2468_ACE0, 32'h74,  3'b010, 1'b1);

        // Reset in a stalled data phase, then let the held request re-issue.
        mem_valid = 1'b1; mem_instr = 1'b0; mem_addr = 32'h40; mem_wdata = 32'h0; mem_wstrb = 4'b0000;
        @(negedge clk);
        check_eq("pre_reset_htrans", {30'd0, htrans}, 32'd2);
        @(negedge clk);
        hready = 1'b0;
        hreset = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        hreset = 1'b0; hready = 1'b1; berr_model = 1'b0;
        $display("txn mid-transfer reset applied");
        txn(32'h40,  4'b0000, 32'h0,         1'b0, 0, 1'b0, 32'h1357_9BDF, 32'h40,  3'b010, 1'b1);

        check_eq("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
